// File: rtl/adder_seq_ctrl.sv
// Nibble-serial add/subtract sequencer driving one shared external 4-bit adder slice.
// Optional signed-overflow output out_ovf is built when ADD_SEQ_OVF_EN is defined.
module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   out_zero,
`ifdef ADD_SEQ_OVF_EN
    output logic                   out_ovf,
`endif
    output logic [3:0]             ADD_A,
    output logic [3:0]             ADD_B,
    output logic                   ADD_CIN,
    input  logic [3:0]             ADD_SUM,
    input  logic                   ADD_COUT,
    output logic [1:0]             dbg_state
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = $clog2(NIBBLES);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    // Handshake rules: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE, out_valid only in DONE; the result is held
    // unchanged in DONE until out_ready is seen.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_n;
    logic [W-1:0]   a_q, b_q, sum_q, sum_next;
    logic           sub_q, carry_q, zero_q;
    logic [KW-1:0]  k_q;
    logic           last_nibble;

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_sum     = sum_q;
    assign out_cout    = carry_q;
    assign out_zero    = zero_q;
    assign dbg_state   = state_q;
    assign last_nibble = (k_q == K_LAST);

    always_comb begin
        state_n  = state_q;
        ADD_A    = 4'd0;
        ADD_B    = 4'd0;
        ADD_CIN  = 1'b0;
        sum_next = sum_q;
        case (state_q)
            IDLE: begin
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                ADD_A    = a_q[4*k_q +: 4];
                ADD_B    = b_q[4*k_q +: 4];
                // First nibble takes the +1 of two's complement for subtract.
                ADD_CIN  = (k_q == '0) ? sub_q : carry_q;
                sum_next[4*k_q +: 4] = ADD_SUM;
                if (last_nibble) state_n = DONE;
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_n;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b ^ {W{in_sub}};
                        sub_q   <= in_sub;
                        carry_q <= 1'b0;
                        zero_q  <= 1'b0;
                        k_q     <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_next;
                    carry_q <= ADD_COUT;
                    if (last_nibble) begin
                        zero_q <= (sum_next == '0);
                        k_q    <= '0;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADD_SEQ_OVF_EN
    logic ovf_q;
    assign out_ovf = ovf_q;

    // Same-sign operands producing a differently-signed result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_nibble) begin
            ovf_q <= (a_q[W-1] == b_q[W-1]) && (ADD_SUM[3] != a_q[W-1]);
        end
    end
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: table vectors, hold/reset sequences and random ops
// checked against an arithmetic reference model; the 4-bit adder slice lives here.
module tb_adder_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_sub;
    logic [W-1:0]  in_a, in_b;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout, out_zero;
    logic [3:0]    add_a, add_b, add_sum;
    logic          add_cin, add_cout;
    logic [1:0]    dbg_state;
`ifdef ADD_SEQ_OVF_EN
    logic          out_ovf;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    // Expected {ovf, zero, cout, sum} per issued operation.
    logic [W+2:0] exp_q[$];

    always #5 clk = ~clk;

    // External adder_4bit slice.
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    adder_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_zero(out_zero),
`ifdef ADD_SEQ_OVF_EN
        .out_ovf(out_ovf),
`endif
        .ADD_A(add_a), .ADD_B(add_b), .ADD_CIN(add_cin),
        .ADD_SUM(add_sum), .ADD_COUT(add_cout),
        .dbg_state(dbg_state)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         zero;
        logic         ovf;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        int unsigned ua, ub;
        int sa, sb, sr;
        logic [W-1:0] r;
        logic c, z, v;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        if (sub) begin
            r  = W'(ua - ub);
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = W'(ua + ub);
            c  = ((ua + ub) >= (1 << W));
            sr = sa + sb;
        end
        z = (r == '0);
        v = (sr > 32767) || (sr < -32768);
        return {v, z, c, r};
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sum"},   32'(out_sum),   32'd0);
        check({tag, "_out_cout"},  32'(out_cout),  32'd0);
        check({tag, "_out_zero"},  32'(out_zero),  32'd0);
        check({tag, "_add_bus"},   32'({add_a, add_b, add_cin}), 32'd0);
    endtask

    // Issue one op (called at a negedge), then check the result against exp_q.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input int hold);
        logic [W+2:0] e;
        logic [W-1:0] held;
        int lat;
        exp_q.push_back(model(a, b, sub));
        check("in_ready_before", 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        check("latency", 32'(lat), 32'(NIB));
        if (!out_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        check("sum",  32'(out_sum),  32'(e[W-1:0]));
        check("cout", 32'(out_cout), 32'(e[W]));
        check("zero", 32'(out_zero), 32'(e[W+1]));
`ifdef ADD_SEQ_OVF_EN
        check("ovf",  32'(out_ovf),  32'(e[W+2]));
`endif
        check("add_bus_done", 32'({add_a, add_b, add_cin}), 32'd0);
        held = out_sum;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a = W'($urandom); in_b = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready),  32'd0);
            check("hold_sum",   32'(out_sum),   32'(held));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready),  32'd1);
    endtask

    initial begin
        tbl[0] = '{16'h0003, 16'h0001, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1};
        tbl[9] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};

        do_reset();
        check_idle("reset");

        // Table vectors: compare the hand-derived constants, then run the op.
        foreach (tbl[i]) begin
            logic [W+2:0] m;
            m = model(tbl[i].a, tbl[i].b, tbl[i].sub);
            check("model_vs_table", 32'(m), 32'({tbl[i].ovf, tbl[i].zero, tbl[i].cout, tbl[i].sum}));
            run_op(tbl[i].a, tbl[i].b, tbl[i].sub, 0);
        end

        // Result held with out_ready low while in_valid pulses are ignored.
        run_op(16'hABCD, 16'h1357, 1'b0, 5);

        // Reset in the middle of RUN at nibble index 2.
        in_a = 16'hFFFF; in_b = 16'hFFFF; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_run_rst");
        run_op(16'h1234, 16'h1111, 1'b0, 0);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
